var_state_bank: RTL and testbench
=================================

Name: var_state_bank

Overview:
- Parametrised successor of the single-variable state cell. Holds value and level state for NUM_VARS variables of one Sat Engine bin in a single block.
- Adds the following, which the single cell does not have:
  - indexed decision;
  - a registered learnt-clause reduction (max level, saturating length);
  - a serial load/store engine with valid/ready handshakes for swapping bin state in and out.
- Sits between the clause array (value_i/value_o) and the bin controller (decide/imply/analyze/backtrack/load/store sequencing).

Parameters:
- NUM_VARS, 8: variables held in the bank.
- WIDTH_LVL, 10: decision-level width.
- WIDTH_IDX, 3: variable index width; must satisfy 2^WIDTH_IDX >= NUM_VARS.
- WIDTH_C_LEN, 4: learnt-clause length width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- value_i  in  3*NUM_VARS  per-var value from clause array, {pol[1:0], implied}
- value_o  out  3*NUM_VARS  per-var value to clause array
- cur_lvl_i  in  WIDTH_LVL  current decision level
- dec_valid_i  in  1  decide pulse
- dec_idx_i  in  WIDTH_IDX  variable to decide
- apply_imply_i  in  1  accept implications
- find_imply_o  out  1  OR of all implied flags
- find_conflict_o  out  1  any var with pol==11
- apply_analyze_i  in  1  conflict analysis active
- max_lvl_o  out  WIDTH_LVL  max level over learnt literals (registered)
- clause_len_o  out  WIDTH_C_LEN  learnt literal count, saturating (registered)
- apply_bkt_i  in  1  backtrack pulse
- bkt_lvl_i  in  WIDTH_LVL  backtrack target level
- load_start_i  in  1  begin serial load
- store_start_i  in  1  begin serial store
- busy_o  out  1  load/store engine active
- ld_valid_i  in  1  load beat valid
- ld_ready_o  out  1  load beat accepted
- ld_state_i  in  3+WIDTH_LVL  {value, lvl} for var at index idx_o
- st_valid_o  out  1  store beat valid
- st_ready_i  in  1  store beat consumed
- st_state_o  out  3+WIDTH_LVL  {value, lvl} for var at index idx_o
- idx_o  out  WIDTH_IDX  current load/store index

Behaviour:
Reset (rst low, asynchronous) clears all of the following:
- every var value to 3'b111, lvl to 0, saved value to 0, learnt lit to 0;
- max_lvl_o=0, clause_len_o=0, busy_o=0, ld_ready_o=0, st_valid_o=0, idx_o=0, FSM=IDLE.

Per-var update, priority high to low. Evaluated only when the FSM is IDLE; apply_* and dec_valid_i are ignored while busy_o=1.
1. Decide: dec_valid_i and dec_idx_i==k sets value to 010 and lvl to cur_lvl_i.
2. Imply: apply_imply_i and value_i[0] sets value to value_i and lvl to cur_lvl_i.
3. Analyze: apply_analyze_i and value_i[2:1]==11 sets value to value_i.
4. Backtrack: apply_bkt_i and lvl>bkt_lvl_i sets value to 000.
5. Flip: apply_bkt_i and learnt!=00 and lvl==bkt_lvl_i sets value to {~saved[2:1], saved[0]}.

Saved value and learnt literal:
- Saved value tracks value every cycle while apply_analyze_i=0, and holds while it is 1.
- Learnt lit is set to ~saved[2:1] when value[2:1]==11 and any of: lvl!=cur_lvl_i, value[0]==0, or value_i[0]==0.
- Learnt lit holds during analyze and clears to 00 otherwise.

Output mapping:
- value_o = apply_analyze_i ? {learnt,0} : value, per var.
- find_* outputs are combinational from the registered values.

Reduction (1-cycle latency):
- max_lvl_o registers the max lvl over vars with learnt!=00, or 0 if there are none.
- clause_len_o registers the popcount of learnt!=00, saturating at 2^WIDTH_C_LEN-1.

Load/store FSM, states IDLE, LOAD, STORE:
- IDLE to LOAD on load_start_i; IDLE to STORE on store_start_i. If both are asserted, load wins. On entry, idx_o=0 and busy_o=1.
- LOAD: ld_ready_o=1. A beat transfers when ld_valid_i && ld_ready_o; it writes var[idx_o] and increments idx_o. After the beat at idx NUM_VARS-1, the FSM goes to IDLE, idx_o returns to 0, and busy_o is 0 on the next cycle. With no valid beat, the FSM holds.
- STORE: st_valid_o=1 and st_state_o=var[idx_o]. A beat completes when st_ready_i=1; the index then advances, and after the last index the FSM goes to IDLE. st_state_o stays stable while st_ready_i=0.
- Start pulses received while busy are ignored. The var index does not wrap past NUM_VARS-1 when NUM_VARS < 2^WIDTH_IDX.

Test Plan:
- Reset mid-LOAD at idx 3: rst low immediately forces busy_o=0, all values=111, idx_o=0; after release, FSM=IDLE.
- dec_valid_i with idx=2, cur_lvl=5: next cycle var2 value=010, lvl=5; others unchanged.
- Conflict: var1 lvl 3 (cur 5) and var4 lvl 5 decided, both driven to value_i=110 during analyze: learnt lits set on var1 and var4; one cycle later clause_len_o=2, max_lvl_o=5.
- Backtrack bkt_lvl=3 after that analysis: var4 (lvl 5) value becomes 000; var1 (lvl 3, learnt) flips to {~saved[2:1], saved[0]}.
- LOAD of 8 beats with ld_valid_i low on the 3rd cycle: exactly 8 transfers, idx_o runs 0..7, busy_o falls after beat 7, and a dec_valid_i asserted during load is ignored.
- STORE with st_ready_i held low for 2 cycles at idx 4: st_state_o stable; completes after 8 accepted beats.

Source files
------------

// File: rtl/var_state_bank.sv
// Variable state bank for one Sat Engine bin: per-variable value/level cells,
// learnt-clause reduction, and a serial load/store engine for bin swapping.
module var_state_bank #(
  parameter int NUM_VARS    = 8,
  parameter int WIDTH_LVL   = 10,
  parameter int WIDTH_IDX   = 3,
  parameter int WIDTH_C_LEN = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [3*NUM_VARS-1:0]    value_i,
  output logic [3*NUM_VARS-1:0]    value_o,
  input  logic [WIDTH_LVL-1:0]     cur_lvl_i,
  input  logic                     dec_valid_i,
  input  logic [WIDTH_IDX-1:0]     dec_idx_i,
  input  logic                     apply_imply_i,
  output logic                     find_imply_o,
  output logic                     find_conflict_o,
  input  logic                     apply_analyze_i,
  output logic [WIDTH_LVL-1:0]     max_lvl_o,
  output logic [WIDTH_C_LEN-1:0]   clause_len_o,
  input  logic                     apply_bkt_i,
  input  logic [WIDTH_LVL-1:0]     bkt_lvl_i,
  input  logic                     load_start_i,
  input  logic                     store_start_i,
  output logic                     busy_o,
  input  logic                     ld_valid_i,
  output logic                     ld_ready_o,
  input  logic [3+WIDTH_LVL-1:0]   ld_state_i,
  output logic                     st_valid_o,
  input  logic                     st_ready_i,
  output logic [3+WIDTH_LVL-1:0]   st_state_o,
  output logic [WIDTH_IDX-1:0]     idx_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_STORE} state_t;

  localparam logic [WIDTH_IDX-1:0] LAST_IDX = WIDTH_IDX'(NUM_VARS - 1);
  localparam int                   LEN_MAX  = (1 << WIDTH_C_LEN) - 1;

  state_t                             state_reg, state_next;
  logic [WIDTH_IDX-1:0]               idx_reg, idx_next;
  logic                               idle;
  logic                               analyze_act;
  logic                               ld_fire;

  logic [NUM_VARS-1:0][2:0]           val_all;
  logic [NUM_VARS-1:0][WIDTH_LVL-1:0] lvl_all;
  logic [NUM_VARS-1:0]                learnt_any;
  logic [NUM_VARS-1:0]                implied_vec;
  logic [NUM_VARS-1:0]                conflict_vec;

  logic [WIDTH_LVL-1:0]               max_lvl_reg, max_lvl_next;
  logic [WIDTH_C_LEN-1:0]             len_reg, len_next;
  int                                 learnt_cnt;

  // Bin-level commands only act while the swap engine is parked.
  assign idle        = (state_reg == ST_IDLE);
  assign analyze_act = apply_analyze_i && idle;
  assign ld_fire     = (state_reg == ST_LOAD) && ld_valid_i;

  for (genvar gi = 0; gi < NUM_VARS; gi++) begin : g_var
    localparam logic [WIDTH_IDX-1:0] MY_IDX = WIDTH_IDX'(gi);

    logic [2:0]           val_reg, val_next;
    logic [WIDTH_LVL-1:0] lvl_reg, lvl_next;
    logic [2:0]           saved_reg, saved_next;
    logic [1:0]           learnt_reg, learnt_next;
    logic [2:0]           vin;
    logic                 ld_we;
    logic                 learnt_cond;

    assign vin   = value_i[3*gi +: 3];
    assign ld_we = ld_fire && (idx_reg == MY_IDX);

    always_comb begin
      val_next = val_reg;
      lvl_next = lvl_reg;
      if (ld_we) begin
        val_next = ld_state_i[WIDTH_LVL +: 3];
        lvl_next = ld_state_i[WIDTH_LVL-1:0];
      end else if (idle) begin
        if (dec_valid_i && (dec_idx_i == MY_IDX)) begin
          val_next = 3'b010;
          lvl_next = cur_lvl_i;
        end else if (apply_imply_i && vin[0]) begin
          val_next = vin;
          lvl_next = cur_lvl_i;
        end else if (apply_analyze_i && (vin[2:1] == 2'b11)) begin
          val_next = vin;
        end else if (apply_bkt_i && (lvl_reg > bkt_lvl_i)) begin
          val_next = 3'b000;
        end else if (apply_bkt_i && (learnt_reg != 2'b00) && (lvl_reg == bkt_lvl_i)) begin
          // Asserting level of the learnt clause: flip to the opposite polarity.
          val_next = {~saved_reg[2:1], saved_reg[0]};
        end
      end
    end

    // A conflicting var contributes its pre-conflict literal negated.
    assign learnt_cond = (val_reg[2:1] == 2'b11) &&
                         ((lvl_reg != cur_lvl_i) || !val_reg[0] || !vin[0]);

    always_comb begin
      saved_next  = analyze_act ? saved_reg : val_reg;
      learnt_next = 2'b00;
      if (analyze_act) begin
        learnt_next = learnt_cond ? ~saved_reg[2:1] : learnt_reg;
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        val_reg    <= 3'b111;
        lvl_reg    <= '0;
        saved_reg  <= 3'b000;
        learnt_reg <= 2'b00;
      end else begin
        val_reg    <= val_next;
        lvl_reg    <= lvl_next;
        saved_reg  <= saved_next;
        learnt_reg <= learnt_next;
      end
    end

    assign value_o[3*gi +: 3] = analyze_act ? {learnt_reg, 1'b0} : val_reg;
    assign val_all[gi]        = val_reg;
    assign lvl_all[gi]        = lvl_reg;
    assign learnt_any[gi]     = |learnt_reg;
    assign implied_vec[gi]    = val_reg[0];
    assign conflict_vec[gi]   = (val_reg[2:1] == 2'b11);
  end

  assign find_imply_o    = |implied_vec;
  assign find_conflict_o = |conflict_vec;

  always_comb begin
    max_lvl_next = '0;
    learnt_cnt   = 0;
    for (int i = 0; i < NUM_VARS; i++) begin
      if (learnt_any[i]) begin
        learnt_cnt = learnt_cnt + 1;
        if (lvl_all[i] > max_lvl_next) begin
          max_lvl_next = lvl_all[i];
        end
      end
    end
    len_next = (learnt_cnt > LEN_MAX) ? WIDTH_C_LEN'(LEN_MAX) : WIDTH_C_LEN'(learnt_cnt);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      max_lvl_reg <= '0;
      len_reg     <= '0;
    end else begin
      max_lvl_reg <= max_lvl_next;
      len_reg     <= len_next;
    end
  end

  assign max_lvl_o    = max_lvl_reg;
  assign clause_len_o = len_reg;

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    case (state_reg)
      ST_IDLE: begin
        if (load_start_i) begin
          state_next = ST_LOAD;
          idx_next   = '0;
        end else if (store_start_i) begin
          state_next = ST_STORE;
          idx_next   = '0;
        end
      end
      ST_LOAD: begin
        if (ld_valid_i) begin
          if (idx_reg == LAST_IDX) begin
            state_next = ST_IDLE;
            idx_next   = '0;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end
      ST_STORE: begin
        if (st_ready_i) begin
          if (idx_reg == LAST_IDX) begin
            state_next = ST_IDLE;
            idx_next   = '0;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        idx_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  assign busy_o     = (state_reg != ST_IDLE);
  assign ld_ready_o = (state_reg == ST_LOAD);
  assign st_valid_o = (state_reg == ST_STORE);
  assign idx_o      = idx_reg;
  // Index only advances on an accepted beat, so the read data holds while stalled.
  assign st_state_o = {val_all[idx_reg], lvl_all[idx_reg]};

endmodule

// File: tb/tb_var_state_bank.sv
// Directed + randomized bench for var_state_bank against a behavioural model
// of the bank's value/level rules and the load/store sequencing.
module tb_var_state_bank;

  localparam int NV = 8;
  localparam int WL = 10;
  localparam int WI = 3;
  localparam int WC = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [3*NV-1:0] value_i;
  logic [3*NV-1:0] value_o;
  logic [WL-1:0]   cur_lvl;
  logic            dec_valid;
  logic [WI-1:0]   dec_idx;
  logic            apply_imply;
  logic            find_imply;
  logic            find_conflict;
  logic            apply_analyze;
  logic [WL-1:0]   max_lvl;
  logic [WC-1:0]   clause_len;
  logic            apply_bkt;
  logic [WL-1:0]   bkt_lvl;
  logic            load_start;
  logic            store_start;
  logic            busy;
  logic            ld_valid;
  logic            ld_ready;
  logic [WL+2:0]   ld_state;
  logic            st_valid;
  logic            st_ready;
  logic [WL+2:0]   st_state;
  logic [WI-1:0]   idx;

  var_state_bank #(.NUM_VARS(NV), .WIDTH_LVL(WL), .WIDTH_IDX(WI), .WIDTH_C_LEN(WC)) dut (
    .clk(clk), .rst(rst),
    .value_i(value_i), .value_o(value_o),
    .cur_lvl_i(cur_lvl),
    .dec_valid_i(dec_valid), .dec_idx_i(dec_idx),
    .apply_imply_i(apply_imply), .find_imply_o(find_imply), .find_conflict_o(find_conflict),
    .apply_analyze_i(apply_analyze), .max_lvl_o(max_lvl), .clause_len_o(clause_len),
    .apply_bkt_i(apply_bkt), .bkt_lvl_i(bkt_lvl),
    .load_start_i(load_start), .store_start_i(store_start), .busy_o(busy),
    .ld_valid_i(ld_valid), .ld_ready_o(ld_ready), .ld_state_i(ld_state),
    .st_valid_o(st_valid), .st_ready_i(st_ready), .st_state_o(st_state),
    .idx_o(idx)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: 0 = idle, 1 = loading, 2 = storing.
  logic [2:0]    m_val    [NV];
  logic [WL-1:0] m_lvl    [NV];
  logic [2:0]    m_saved  [NV];
  logic [1:0]    m_learnt [NV];
  int            m_state;
  int            m_idx;
  logic [WL-1:0] m_max;
  int            m_len;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NV; k++) begin
      m_val[k] = 3'b111; m_lvl[k] = '0; m_saved[k] = 3'b000; m_learnt[k] = 2'b00;
    end
    m_state = 0; m_idx = 0; m_max = '0; m_len = 0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_clock();
    logic [2:0]    nv [NV];
    logic [WL-1:0] nl [NV];
    logic [2:0]    ns [NV];
    logic [1:0]    nt [NV];
    logic [2:0]    vi;
    logic [WL-1:0] mx;
    int            cnt;
    bit            idl;
    bit            an;
    idl = (m_state == 0);
    an  = idl && apply_analyze;
    cnt = 0; mx = '0;
    for (int k = 0; k < NV; k++) begin
      if (m_learnt[k] != 2'b00) begin
        cnt++;
        if (m_lvl[k] > mx) mx = m_lvl[k];
      end
    end
    for (int k = 0; k < NV; k++) begin
      vi = value_i[3*k +: 3];
      nv[k] = m_val[k]; nl[k] = m_lvl[k];
      if (idl) begin
        if (dec_valid && int'(dec_idx) == k) begin nv[k] = 3'b010; nl[k] = cur_lvl; end
        else if (apply_imply && vi[0]) begin nv[k] = vi; nl[k] = cur_lvl; end
        else if (apply_analyze && vi[2:1] == 2'b11) nv[k] = vi;
        else if (apply_bkt && m_lvl[k] > bkt_lvl) nv[k] = 3'b000;
        else if (apply_bkt && m_learnt[k] != 2'b00 && m_lvl[k] == bkt_lvl)
          nv[k] = {~m_saved[k][2:1], m_saved[k][0]};
      end
      ns[k] = an ? m_saved[k] : m_val[k];
      nt[k] = 2'b00;
      if (an) begin
        if (m_val[k][2:1] == 2'b11 && (m_lvl[k] != cur_lvl || !m_val[k][0] || !vi[0]))
          nt[k] = ~m_saved[k][2:1];
        else
          nt[k] = m_learnt[k];
      end
    end
    case (m_state)
      0: begin
        if (load_start) begin m_state = 1; m_idx = 0; end
        else if (store_start) begin m_state = 2; m_idx = 0; end
      end
      1: begin
        if (ld_valid) begin
          nv[m_idx] = ld_state[WL+2:WL];
          nl[m_idx] = ld_state[WL-1:0];
          if (m_idx == NV-1) begin m_state = 0; m_idx = 0; end else m_idx++;
        end
      end
      default: begin
        if (st_ready) begin
          if (m_idx == NV-1) begin m_state = 0; m_idx = 0; end else m_idx++;
        end
      end
    endcase
    for (int k = 0; k < NV; k++) begin
      m_val[k] = nv[k]; m_lvl[k] = nl[k]; m_saved[k] = ns[k]; m_learnt[k] = nt[k];
    end
    m_max = mx;
    m_len = (cnt > 15) ? 15 : cnt;
  endtask

  task automatic check_all();
    bit         an;
    bit         fi;
    bit         fc;
    logic [2:0] e;
    an = (m_state == 0) && apply_analyze;
    fi = 1'b0; fc = 1'b0;
    for (int k = 0; k < NV; k++) begin
      e = an ? {m_learnt[k], 1'b0} : m_val[k];
      chk($sformatf("value_o[%0d]", k), 32'(value_o[3*k +: 3]), 32'(e));
      fi |= m_val[k][0];
      fc |= (m_val[k][2:1] == 2'b11);
    end
    chk("find_imply", 32'(find_imply), 32'(fi));
    chk("find_conflict", 32'(find_conflict), 32'(fc));
    chk("max_lvl", 32'(max_lvl), 32'(m_max));
    chk("clause_len", 32'(clause_len), 32'(m_len));
    chk("busy", 32'(busy), 32'(m_state != 0));
    chk("idx", 32'(idx), 32'(m_idx));
    chk("ld_ready", 32'(ld_ready), 32'(m_state == 1));
    chk("st_valid", 32'(st_valid), 32'(m_state == 2));
    if (m_state == 2) chk("st_state", 32'(st_state), 32'({m_val[m_idx], m_lvl[m_idx]}));
  endtask

  task automatic step();
    model_clock();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    int            xfers;
    int            beats;
    int            hold;
    bit            was_low;
    logic [WL+2:0] snap;
    logic [WL+2:0] first_ld;

    rst = 1'b0; value_i = '0; cur_lvl = '0; dec_valid = 1'b0; dec_idx = '0;
    apply_imply = 1'b0; apply_analyze = 1'b0; apply_bkt = 1'b0; bkt_lvl = '0;
    load_start = 1'b0; store_start = 1'b0; ld_valid = 1'b0; ld_state = '0; st_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    $display("[TB] reset state checked");
    @(negedge clk) rst = 1'b1;

    // Reset asserted in the middle of a load.
    load_start = 1'b1; step(); load_start = 1'b0;
    ld_valid = 1'b1;
    for (int b = 0; b < 3; b++) begin ld_state = 13'($urandom); step(); end
    chk("mid_load_idx", 32'(idx), 32'd3);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_all();
    ld_valid = 1'b0;
    @(negedge clk) rst = 1'b1;
    step();
    $display("[TB] reset mid-load checked");

    // Decide var2 at level 5.
    cur_lvl = 10'd5; dec_valid = 1'b1; dec_idx = 3'd2; step(); dec_valid = 1'b0;
    chk("decide_var2", 32'(value_o[8:6]), 32'd2);
    $display("[TB] decide var2 lvl5");

    // Conflict analysis over var1 (lvl 3) and var4 (lvl 5).
    cur_lvl = 10'd3; dec_valid = 1'b1; dec_idx = 3'd1; step();
    cur_lvl = 10'd5; dec_idx = 3'd4; step();
    dec_valid = 1'b0; step();
    apply_analyze = 1'b1;
    value_i = '0; value_i[5:3] = 3'b110; value_i[14:12] = 3'b110;
    step(); step();
    chk("learnt_var1", 32'(value_o[5:3]), 32'b100);
    chk("learnt_var4", 32'(value_o[14:12]), 32'b100);
    step();
    chk("clause_len_2", 32'(clause_len), 32'd2);
    chk("max_lvl_5", 32'(max_lvl), 32'd5);
    $display("[TB] analyze: len=%0d max=%0d", clause_len, max_lvl);

    // Backtrack to level 3 right after analysis.
    apply_analyze = 1'b0; value_i = '0; apply_bkt = 1'b1; bkt_lvl = 10'd3; step(); apply_bkt = 1'b0;
    chk("bkt_var4_cleared", 32'(value_o[14:12]), 32'b000);
    chk("bkt_var1_flipped", 32'(value_o[5:3]), 32'b100);
    $display("[TB] backtrack to lvl3");

    // Load of 8 beats with a valid gap; decide requests during load must be ignored.
    load_start = 1'b1; step(); load_start = 1'b0;
    dec_valid = 1'b1; dec_idx = 3'd0; cur_lvl = 10'd9;
    xfers = 0; first_ld = '0;
    for (int c = 0; c < 20 && busy; c++) begin
      ld_valid = (c != 2);
      ld_state = 13'($urandom);
      if (ld_valid && ld_ready) begin
        chk("ld_idx", 32'(idx), 32'(xfers));
        if (xfers == 0) first_ld = ld_state;
        $display("[TB] load beat idx=%0d state=0x%0h", idx, ld_state);
        xfers++;
      end
      step();
    end
    dec_valid = 1'b0; ld_valid = 1'b0;
    chk("ld_beats", 32'(xfers), 32'd8);
    chk("ld_var0", 32'(value_o[2:0]), 32'(first_ld[WL+2:WL]));

    // Store with a 2-cycle stall at index 4.
    store_start = 1'b1; step(); store_start = 1'b0;
    beats = 0; hold = 0;
    for (int c = 0; c < 30 && busy; c++) begin
      if (m_idx == 4 && hold < 2) begin st_ready = 1'b0; hold++; end
      else st_ready = 1'b1;
      snap = st_state;
      was_low = !st_ready;
      if (st_ready && st_valid) begin
        $display("[TB] store beat idx=%0d state=0x%0h", idx, st_state);
        beats++;
      end
      step();
      if (was_low) chk("st_stable", 32'(st_state), 32'(snap));
    end
    st_ready = 1'b0;
    chk("st_beats", 32'(beats), 32'd8);

    // Randomized mix of every command against the model.
    for (int c = 0; c < 400; c++) begin
      cur_lvl       = 10'($urandom_range(0, 7));
      dec_valid     = ($urandom_range(0, 4) == 0);
      dec_idx       = 3'($urandom);
      apply_imply   = ($urandom_range(0, 4) == 0);
      apply_analyze = ($urandom_range(0, 2) == 0);
      apply_bkt     = ($urandom_range(0, 5) == 0);
      bkt_lvl       = 10'($urandom_range(0, 7));
      value_i       = 24'($urandom);
      load_start    = ($urandom_range(0, 40) == 0);
      store_start   = ($urandom_range(0, 40) == 0);
      ld_valid      = ($urandom_range(0, 3) != 0);
      ld_state      = 13'($urandom);
      st_ready      = ($urandom_range(0, 3) != 0);
      step();
    end
    $display("[TB] random phase done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
